// File: rtl/hvac_pkg.sv
// ---------------------------------------------------------------------------
// hvac_pkg : shared state encoding and default timing constants for the
//            HVAC relay sequencer.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } hvac_state_e;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_MIN_ON  = 30;
  localparam int DEF_MIN_OFF = 60;

endpackage

`default_nettype wire

// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer : saturating tick counter; clear has priority over enable.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != C_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hvac_relay_ctrl.sv
// ---------------------------------------------------------------------------
// hvac_relay_ctrl : heater/cooler relay sequencer enforcing minimum on-time,
//                   minimum off-time and mutual exclusion.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hvac_relay_ctrl
  import hvac_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       Hon,
  input  logic       Con,
  output logic       heat_out,
  output logic       cool_out,
  output logic       fault,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] C_MIN_ON  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] C_MIN_OFF = CNT_W'(MIN_OFF);

  hvac_state_e      state_q;
  hvac_state_e      state_d;
  logic             fault_q;
  logic [CNT_W-1:0] timer_q;
  logic             heat_dem;
  logic             cool_dem;
  logic             state_chg;

  // Simultaneous demands cancel out rather than picking a winner.
  assign heat_dem  = Hon & ~Con;
  assign cool_dem  = Con & ~Hon;
  assign state_chg = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (heat_dem && (timer_q >= C_MIN_OFF)) begin
          state_d = HEAT;
        end else if (cool_dem && (timer_q >= C_MIN_OFF)) begin
          state_d = COOL;
        end
      end
      HEAT: begin
        if (!heat_dem && (timer_q >= C_MIN_ON)) begin
          state_d = IDLE;
        end
      end
      COOL: begin
        if (!cool_dem && (timer_q >= C_MIN_ON)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= Hon & Con;
    end
  end

  // Timer restarts on every state change so each dwell is measured afresh.
  tick_timer #(
    .CNT_W (CNT_W)
  ) u_tick_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_chg),
    .en_i    (tick),
    .count_o (timer_q)
  );

  assign heat_out = (state_q == HEAT);
  assign cool_out = (state_q == COOL);
  assign fault    = fault_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hvac_relay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hvac_relay_ctrl : directed bench for hvac_relay_ctrl (CNT_W=4, MIN_ON=3,
//                      MIN_OFF=2, tick on every 4th clock edge).
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hvac_relay_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       Hon;
  logic       Con;
  logic       heat_out;
  logic       cool_out;
  logic       fault;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;

  always #5 clk = ~clk;

  hvac_relay_ctrl #(
    .CNT_W   (4),
    .MIN_ON  (3),
    .MIN_OFF (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .Hon      (Hon),
    .Con      (Con),
    .heat_out (heat_out),
    .cool_out (cool_out),
    .fault    (fault),
    .state    (state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // Edge e is ticked when e is a multiple of 4, counted from reset release.
  task automatic step();
    tick = ((e + 1) % 4 == 0);
    @(posedge clk);
    #1;
    e++;
    tick = 1'b0;
    chk("excl", {7'b0, heat_out & cool_out}, 8'd0);
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    Hon   = 1'b1;
    Con   = 1'b0;
    #12;
    chk("rst_state", {6'b0, state}, 8'd0);
    chk("rst_heat", {7'b0, heat_out}, 8'd0);
    chk("rst_cool", {7'b0, cool_out}, 8'd0);
    chk("rst_fault", {7'b0, fault}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;

    // Power-up: timer hits 2 at edge 8, relay on at edge 9
    run_to(8);
    chk("pwr_heat_wait", {7'b0, heat_out}, 8'd0);
    chk("pwr_fault", {7'b0, fault}, 8'd0);
    run_to(9);
    chk("pwr_heat_on", {7'b0, heat_out}, 8'd1);
    chk("pwr_state", {6'b0, state}, 8'd1);
    chk("pwr_cool", {7'b0, cool_out}, 8'd0);

    // Short demand: dropped after first tick, held until timer 3 at edge 20
    run_to(12);
    Hon = 1'b0;
    run_to(20);
    chk("short_hold", {7'b0, heat_out}, 8'd1);
    run_to(21);
    chk("short_drop", {7'b0, heat_out}, 8'd0);
    chk("short_state", {6'b0, state}, 8'd0);

    // Changeover: heat 29..40, idle 41..48, cool at 49
    Hon = 1'b1;
    run_to(28);
    chk("chg_heat_wait", {7'b0, heat_out}, 8'd0);
    run_to(29);
    chk("chg_heat_on", {7'b0, heat_out}, 8'd1);
    run_to(40);
    Hon = 1'b0;
    Con = 1'b1;
    run_to(41);
    chk("chg_heat_off", {7'b0, heat_out}, 8'd0);
    chk("chg_cool_off", {7'b0, cool_out}, 8'd0);
    run_to(48);
    chk("chg_deadtime", {7'b0, cool_out}, 8'd0);
    run_to(49);
    chk("chg_cool_on", {7'b0, cool_out}, 8'd1);
    chk("chg_state", {6'b0, state}, 8'd2);

    // Reset mid-COOL between edges
    rst_n = 1'b0;
    #2;
    chk("arst_cool", {7'b0, cool_out}, 8'd0);
    chk("arst_state", {6'b0, state}, 8'd0);
    #1;
    rst_n = 1'b1;
    e = 0;
    run_to(8);
    chk("arst_cool_wait", {7'b0, cool_out}, 8'd0);
    run_to(9);
    chk("arst_cool_on", {7'b0, cool_out}, 8'd1);

    // Conflict: reach HEAT at 29, both demands, leave at 41, never COOL
    Con = 1'b0;
    run_to(20);
    chk("cfl_cool_hold", {7'b0, cool_out}, 8'd1);
    run_to(21);
    chk("cfl_cool_off", {7'b0, cool_out}, 8'd0);
    Hon = 1'b1;
    run_to(29);
    chk("cfl_heat_on", {7'b0, heat_out}, 8'd1);
    Con = 1'b1;
    run_to(30);
    chk("cfl_fault_set", {7'b0, fault}, 8'd1);
    chk("cfl_in_heat", {6'b0, state}, 8'd1);
    run_to(40);
    chk("cfl_heat_hold", {7'b0, heat_out}, 8'd1);
    run_to(41);
    chk("cfl_idle", {6'b0, state}, 8'd0);
    run_to(52);
    chk("cfl_no_cool", {6'b0, state}, 8'd0);
    chk("cfl_fault_held", {7'b0, fault}, 8'd1);
    Con = 1'b0;
    run_to(53);
    chk("cfl_fault_clr", {7'b0, fault}, 8'd0);
    chk("cfl_heat_resume", {7'b0, heat_out}, 8'd1);

    // Saturation: 16 ticks in IDLE would wrap a 4-bit counter back to 0
    Hon = 1'b0;
    run_to(64);
    chk("sat_heat_hold", {7'b0, heat_out}, 8'd1);
    run_to(65);
    chk("sat_idle", {6'b0, state}, 8'd0);
    run_to(128);
    chk("sat_still_idle", {6'b0, state}, 8'd0);
    Hon = 1'b1;
    run_to(129);
    chk("sat_heat_on", {7'b0, heat_out}, 8'd1);
    chk("sat_state", {6'b0, state}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
